// File: rtl/apb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_queue
// Brief    : Host command FIFO feeding a single-outstanding APB issue FSM that
//            returns read data and error per transfer. Optional WAIT timeout is
//            enabled with the APB_CMDQ_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wen,
    input  logic [8:0]             cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic [$clog2(DEPTH):0] cmd_level,
    output logic                   ST,
    output logic                   WEN,
    output logic [8:0]             APB_WADRS,
    output logic [8:0]             APB_RADRS,
    output logic [7:0]             APB_WDATA,
    input  logic                   xfer_done,
    input  logic [7:0]             APB_RDATA_OUT,
    input  logic                   PSLVERR,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_wen,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic                   busy
);
    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    logic [17:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              r_st, r_wen, r_busy;
    logic [8:0]        r_wadrs, r_radrs;
    logic [7:0]        r_wdata;
    logic              r_rsp_valid, r_rsp_wen, r_rsp_err, r_rsp_timeout;
    logic [7:0]        r_rsp_rdata;
    logic              w_full, w_push, w_pop, w_timeout;
    logic [17:0]       w_head;

    // No bypass: a full FIFO refuses pushes even in a cycle that pops.
    assign w_full = (r_count == c_FULL);
    assign w_push = cmd_valid && !w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_wen, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef APB_CMDQ_TIMEOUT_EN
    localparam int              c_TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);
    logic [c_TW-1:0] r_tcnt;

    // Fires on the last permitted WAIT cycle so RESP follows TIMEOUT_CYCLES WAIT cycles.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_tcnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_tcnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
    assign w_timeout = (r_state == S_WAIT) && (r_tcnt == c_TLAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state       <= S_IDLE;
            r_st          <= 1'b0;
            r_busy        <= 1'b0;
            r_wen         <= 1'b0;
            r_wadrs       <= '0;
            r_radrs       <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_wen     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_LAUNCH;
                        r_st    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_wen   <= w_head[17];
                        r_wadrs <= w_head[17] ? w_head[16:8] : 9'd0;
                        r_radrs <= w_head[17] ? 9'd0 : w_head[16:8];
                        r_wdata <= w_head[17] ? w_head[7:0] : 8'd0;
                    end
                end
                S_LAUNCH: begin
                    r_st    <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (xfer_done) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_wen     <= r_wen;
                        r_rsp_rdata   <= r_wen ? 8'd0 : APB_RDATA_OUT;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_timeout) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_wen     <= r_wen;
                        r_rsp_rdata   <= 8'd0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = !w_full;
    assign cmd_level   = r_count;
    assign ST          = r_st;
    assign WEN         = r_wen;
    assign APB_WADRS   = r_wadrs;
    assign APB_RADRS   = r_radrs;
    assign APB_WDATA   = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_wen     = r_rsp_wen;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_queue
// Brief    : Self-checking bench for apb_cmd_queue: vector table, directed
//            corner sequences and a randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_queue;
    localparam int DEPTH = 4;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_wen = 1'b0;
    logic [8:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       xfer_done = 1'b0, PSLVERR = 1'b0, rsp_ready = 1'b0;
    logic [7:0] APB_RDATA_OUT = '0;
    logic       cmd_ready, ST, WEN, rsp_valid, rsp_wen, rsp_err, rsp_timeout, busy;
    logic [2:0] cmd_level;
    logic [8:0] APB_WADRS, APB_RADRS;
    logic [7:0] APB_WDATA, rsp_rdata;

    int checks = 0;
    int failures = 0;

    apb_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_level(cmd_level),
        .ST(ST), .WEN(WEN), .APB_WADRS(APB_WADRS), .APB_RADRS(APB_RADRS),
        .APB_WDATA(APB_WDATA), .xfer_done(xfer_done), .APB_RDATA_OUT(APB_RDATA_OUT),
        .PSLVERR(PSLVERR), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wen(rsp_wen), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push1(input logic w, input logic [8:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_wen = w; cmd_addr = a; cmd_wdata = d;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
    endtask

    // Finds the next ST pulse, checks the issued command, leaves time in the first WAIT cycle.
    task automatic wait_st(input logic w, input logic [8:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge PCLK);
        while (!ST && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check("st_seen", 32'(ST), 1);
        check("issue_wen", 32'(WEN), 32'(w));
        check("issue_wadrs", 32'(APB_WADRS), w ? 32'(a) : 0);
        check("issue_radrs", 32'(APB_RADRS), w ? 0 : 32'(a));
        check("issue_wdata", 32'(APB_WDATA), w ? 32'(d) : 0);
        @(posedge PCLK); #1;
    endtask

    // Completes the in-flight transfer and accepts the response straight away.
    task automatic finish(input logic w, input logic [7:0] rd, input logic er);
        xfer_done = 1'b1; APB_RDATA_OUT = rd; PSLVERR = er; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        xfer_done = 1'b0; PSLVERR = 1'b0; APB_RDATA_OUT = 8'hEE;
        @(negedge PCLK);
        check("fin_rsp_valid", 32'(rsp_valid), 1);
        check("fin_rsp_wen", 32'(rsp_wen), 32'(w));
        check("fin_rsp_rdata", 32'(rsp_rdata), w ? 0 : 32'(rd));
        check("fin_rsp_err", 32'(rsp_err), 32'(er));
        check("fin_rsp_timeout", 32'(rsp_timeout), 0);
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic       wen;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] bus_rdata;
        logic       bus_err;
        int         delay;
        logic [8:0] exp_wadrs;
        logic [8:0] exp_radrs;
        logic [7:0] exp_wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    logic [17:0] q[$];
    logic [17:0] cur;
    logic [8:0]  fa[6];
    logic        fw[6];
    logic [7:0]  fd[6];

    initial begin
        int n, idx;
        bit rdy, inflight, pend, done_real, exp_ready;
        int wait_left;
        logic e_wen, e_err;
        logic [7:0] e_rd;

        vecs[0] = '{1'b1, 9'h0A5, 8'h3C, 8'h77, 1'b0, 1, 9'h0A5, 9'h000, 8'h3C, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 9'h1F0, 8'h99, 8'h5A, 1'b0, 0, 9'h000, 9'h1F0, 8'h00, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 9'h1FF, 8'hFF, 8'h12, 1'b1, 3, 9'h1FF, 9'h000, 8'hFF, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 9'h000, 8'h55, 8'hC3, 1'b1, 0, 9'h000, 9'h000, 8'h00, 8'hC3, 1'b1};
        vecs[4] = '{1'b1, 9'h100, 8'h01, 8'hAA, 1'b0, 2, 9'h100, 9'h000, 8'h01, 8'h00, 1'b0};

        // Reset state
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_st", 32'(ST), 0);
        check("rst_wen", 32'(WEN), 0);
        check("rst_wadrs", 32'(APB_WADRS), 0);
        check("rst_radrs", 32'(APB_RADRS), 0);
        check("rst_wdata", 32'(APB_WDATA), 0);
        check("rst_rsp", {rsp_valid, rsp_wen, rsp_rdata, rsp_err, rsp_timeout}, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_level", 32'(cmd_level), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        @(posedge PCLK); #1;

        // Vector table: single transfers with exact latency
        for (int i = 0; i < 5; i++) begin
            push1(vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            @(negedge PCLK);
            check("vec_pre_st", 32'(ST), 0);
            check("vec_level1", 32'(cmd_level), 1);
            @(negedge PCLK);
            check("vec_st", 32'(ST), 1);
            check("vec_busy", 32'(busy), 1);
            check("vec_level0", 32'(cmd_level), 0);
            check("vec_wen", 32'(WEN), 32'(vecs[i].wen));
            check("vec_wadrs", 32'(APB_WADRS), 32'(vecs[i].exp_wadrs));
            check("vec_radrs", 32'(APB_RADRS), 32'(vecs[i].exp_radrs));
            check("vec_wdata", 32'(APB_WDATA), 32'(vecs[i].exp_wdata));
            for (int d = 0; d < vecs[i].delay; d++) begin
                @(negedge PCLK);
                check("vec_st_single", 32'(ST), 0);
                check("vec_hold_addr", 32'(APB_WADRS | APB_RADRS), 32'(vecs[i].addr));
                check("vec_no_rsp", 32'(rsp_valid), 0);
            end
            @(posedge PCLK); #1;
            xfer_done = 1'b1; APB_RDATA_OUT = vecs[i].bus_rdata; PSLVERR = vecs[i].bus_err;
            @(negedge PCLK);
            check("vec_rsp_early", 32'(rsp_valid), 0);
            check("vec_st_low", 32'(ST), 0);
            @(posedge PCLK); #1;
            xfer_done = 1'b0; APB_RDATA_OUT = 8'hEE; PSLVERR = 1'b0;
            @(negedge PCLK);
            check("vec_rsp_valid", 32'(rsp_valid), 1);
            check("vec_rsp_wen", 32'(rsp_wen), 32'(vecs[i].wen));
            check("vec_rsp_rdata", 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            check("vec_rsp_err", 32'(rsp_err), 32'(vecs[i].exp_err));
            check("vec_rsp_timeout", 32'(rsp_timeout), 0);
            rsp_ready = 1'b1;
            @(posedge PCLK); #1;
            rsp_ready = 1'b0;
            @(negedge PCLK);
            check("vec_rsp_drop", 32'(rsp_valid), 0);
            check("vec_idle", 32'(busy), 0);
            @(posedge PCLK); #1;
        end

        // Slave error with a stalled response; queued command must wait
        push1(1'b0, 9'h0C3, 8'h00);
        push1(1'b1, 9'h0D4, 8'h5E);
        wait_st(1'b0, 9'h0C3, 8'h00);
        xfer_done = 1'b1; PSLVERR = 1'b1; APB_RDATA_OUT = 8'h81; rsp_ready = 1'b0;
        @(posedge PCLK); #1;
        xfer_done = 1'b0; PSLVERR = 1'b0; APB_RDATA_OUT = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            check("err_rsp_valid", 32'(rsp_valid), 1);
            check("err_rsp_err", 32'(rsp_err), 1);
            check("err_rsp_rdata", 32'(rsp_rdata), 32'h81);
            check("err_no_st", 32'(ST), 0);
            check("err_level", 32'(cmd_level), 1);
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        @(negedge PCLK);
        check("err_rsp_drop", 32'(rsp_valid), 0);
        check("err_idle_no_st", 32'(ST), 0);
        @(negedge PCLK);
        check("err_next_st", 32'(ST), 1);
        check("err_next_wadrs", 32'(APB_WADRS), 32'h0D4);
        @(posedge PCLK); #1;
        finish(1'b1, 8'h00, 1'b0);

        // Back-to-back fill until full, no bypass when full, ordered issue
        fw = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        fa = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
        fd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        idx = 0; n = 0;
        while (idx < 5 && n < 12) begin
            cmd_valid = 1'b1; cmd_wen = fw[idx]; cmd_addr = fa[idx]; cmd_wdata = fd[idx];
            @(negedge PCLK); rdy = cmd_ready;
            @(posedge PCLK); #1;
            if (rdy) idx++;
            n++;
        end
        check("fill_cycles", 32'(n), 5);
        cmd_wen = fw[5]; cmd_addr = fa[5]; cmd_wdata = fd[5];
        @(negedge PCLK);
        check("full_level", 32'(cmd_level), 4);
        check("full_ready", 32'(cmd_ready), 0);
        check("full_first_issued", 32'(APB_WADRS), 32'h011);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("full_refused", 32'(cmd_level), 4);
        finish(1'b1, 8'h00, 1'b0);
        n = 0;
        @(negedge PCLK);
        while (!ST && n < 5) begin @(negedge PCLK); n++; end
        check("nobypass_st", 32'(ST), 1);
        check("nobypass_level", 32'(cmd_level), 3);
        check("nobypass_ready", 32'(cmd_ready), 1);
        check("nobypass_wadrs", 32'(APB_WADRS), 32'h022);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("late_push_level", 32'(cmd_level), 4);
        finish(1'b1, 8'h00, 1'b0);
        for (int k = 2; k < 6; k++) begin
            wait_st(fw[k], fa[k], fd[k]);
            finish(fw[k], 8'h30 + 8'(k), 1'b0);
        end
        @(negedge PCLK);
        check("drain_level", 32'(cmd_level), 0);
        @(posedge PCLK); #1;

`ifdef APB_CMDQ_TIMEOUT_EN
        push1(1'b0, 9'h123, 8'h00);
        APB_RDATA_OUT = 8'hAB;
        wait_st(1'b0, 9'h123, 8'h00);
        n = 1;
        @(negedge PCLK);
        while (!rsp_valid && n < 20) begin @(negedge PCLK); n++; end
        check("to_latency", 32'(n), 9);
        check("to_err", 32'(rsp_err), 1);
        check("to_flag", 32'(rsp_timeout), 1);
        check("to_rdata", 32'(rsp_rdata), 0);
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        push1(1'b0, 9'h124, 8'h00);
        wait_st(1'b0, 9'h124, 8'h00);
        repeat (7) begin @(posedge PCLK); #1; end
        xfer_done = 1'b1; APB_RDATA_OUT = 8'h3D; PSLVERR = 1'b0;
        @(posedge PCLK); #1;
        xfer_done = 1'b0;
        @(negedge PCLK);
        check("tie_valid", 32'(rsp_valid), 1);
        check("tie_timeout", 32'(rsp_timeout), 0);
        check("tie_err", 32'(rsp_err), 0);
        check("tie_rdata", 32'(rsp_rdata), 32'h3D);
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
`else
        push1(1'b0, 9'h124, 8'h00);
        wait_st(1'b0, 9'h124, 8'h00);
        n = 0;
        repeat (80) begin
            @(negedge PCLK);
            if (rsp_valid) n++;
        end
        check("no_timeout_wait", 32'(n), 0);
        finish(1'b0, 8'h3D, 1'b0);
`endif

        // Reset during WAIT with two commands queued
        push1(1'b1, 9'h0A1, 8'h11);
        push1(1'b0, 9'h0A2, 8'h00);
        push1(1'b1, 9'h0A3, 8'h33);
        @(negedge PCLK);
        check("mid_level", 32'(cmd_level), 2);
        check("mid_busy", 32'(busy), 1);
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        xfer_done = 1'b1;
        @(negedge PCLK);
        check("mid_rst_st", 32'(ST), 0);
        check("mid_rst_level", 32'(cmd_level), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        @(posedge PCLK); #1;
        xfer_done = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (rsp_valid || ST) n++;
        end
        check("mid_rst_silent", 32'(n), 0);
        @(posedge PCLK); #1;
        push1(1'b1, 9'h0E7, 8'h42);
        wait_st(1'b1, 9'h0E7, 8'h42);
        finish(1'b1, 8'h00, 1'b0);

        // Randomized traffic against a queue model
        inflight = 0; pend = 0; done_real = 0; wait_left = 0;
        e_wen = 0; e_err = 0; e_rd = 0; cur = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge PCLK);
            if (ST) begin
                check("rnd_st_when_free", {30'd0, inflight, pend}, 0);
                if (q.size() == 0) begin
                    check("rnd_st_with_empty_queue", 32'(q.size()), 1);
                end else begin
                    cur = q.pop_front();
                    check("rnd_issue_wen", 32'(WEN), 32'(cur[17]));
                    check("rnd_issue_wadrs", 32'(APB_WADRS), cur[17] ? 32'(cur[16:8]) : 0);
                    check("rnd_issue_radrs", 32'(APB_RADRS), cur[17] ? 0 : 32'(cur[16:8]));
                    check("rnd_issue_wdata", 32'(APB_WDATA), cur[17] ? 32'(cur[7:0]) : 0);
                end
                inflight = 1;
                wait_left = $urandom_range(0, 3);
            end
            check("rnd_level", 32'(cmd_level), 32'(q.size()));
            check("rnd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(pend));
            if (pend) begin
                check("rnd_rsp_fields", {19'd0, rsp_wen, rsp_rdata, rsp_err, rsp_timeout},
                      {19'd0, e_wen, e_rd, e_err, 1'b0});
            end
            exp_ready = (q.size() < DEPTH);
            @(posedge PCLK);
            if (pend && rsp_ready) pend = 0;
            if (xfer_done && done_real) begin
                pend = 1; inflight = 0;
                e_wen = cur[17]; e_rd = cur[17] ? 8'h00 : APB_RDATA_OUT; e_err = PSLVERR;
            end
            if (cmd_valid && exp_ready) q.push_back({cmd_wen, cmd_addr, cmd_wdata});
            #1;
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_wen = 1'($urandom);
            cmd_addr = 9'($urandom);
            cmd_wdata = 8'($urandom);
            rsp_ready = 1'($urandom);
            APB_RDATA_OUT = 8'($urandom);
            PSLVERR = 1'($urandom);
            xfer_done = 1'b0; done_real = 0;
            if (inflight) begin
                if (wait_left == 0) begin xfer_done = 1'b1; done_real = 1; end
                else wait_left--;
            end else if ($urandom_range(0, 3) == 0) begin
                xfer_done = 1'b1;
            end
        end
        cmd_valid = 1'b0; xfer_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
